// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing and a one-cycle expired pulse.
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload and keep running on terminal count.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             expired,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic             expired_reg;
    logic             busy_reg;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // The reload register is only observable when terminal count reloads from it.
    logic [WIDTH-1:0] reload_reg;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            expired_reg <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reload_reg  <= '0;
`endif
        end else if (clear) begin
            state_reg   <= IDLE;
            q_reg       <= '0;
            expired_reg <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reload_reg  <= '0;
`endif
        end else if (load) begin
            expired_reg <= 1'b0;
            q_reg       <= load_value;
            if (load_value != '0) begin
                state_reg  <= RUN;
                busy_reg   <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                reload_reg <= load_value;
`endif
            end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end
        end else begin
            expired_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (count) begin
                        if (q_reg == WIDTH'(1)) begin
                            expired_reg <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                            q_reg       <= reload_reg;
`else
                            q_reg       <= '0;
                            state_reg   <= DONE;
                            busy_reg    <= 1'b0;
`endif
                        end else if (q_reg > WIDTH'(1)) begin
                            q_reg <= q_reg - WIDTH'(1);
                        end
                    end
                end
                // IDLE and DONE ignore count and hold Q at zero.
                default: begin
                    q_reg    <= '0;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Q       = q_reg;
    assign zero    = (q_reg == '0);
    assign expired = expired_reg;
    assign busy    = busy_reg;

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter and load-value width in bits.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 clear  input  1  SHALL be a synchronous clear to the IDLE state.
REQ-005 load  input  1  SHALL be a synchronous load strobe for load_value.
REQ-006 load_value  input  WIDTH  SHALL be the start value captured on load.
REQ-007 count  input  1  SHALL enable a one-step decrement per cycle.
REQ-008 Q  output  WIDTH  SHALL be the registered current count.
REQ-009 zero  output  1  SHALL be high whenever Q == 0 (combinational from Q).
REQ-010 expired  output  1  SHALL be a registered one-cycle terminal-count pulse.
REQ-011 busy  output  1  SHALL be high exactly while the state is RUN.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 Input priority SHALL be reset_n > clear > load > count.
REQ-014 clear in any state SHALL set state=IDLE, Q=0, reload register=0 and expired=0 on the next edge.
REQ-015 load with load_value != 0 SHALL set Q=load_value, reload register=load_value and state=RUN on the next edge, from any state, including mid-count in RUN.
REQ-016 load with load_value == 0 SHALL set Q=0 and state=IDLE, with no expired pulse.
REQ-017 In RUN with count=1 and Q>1, Q SHALL decrement by 1 per edge.
REQ-018 In RUN with count=0, Q and state SHALL hold.
REQ-019 In RUN with count=1 and Q==1, terminal count SHALL occur: expired=1 in the same cycle the new Q is presented; the Q and state update is per REQ-026.
REQ-020 expired SHALL be high for exactly one cycle per terminal count and low otherwise.
REQ-021 In IDLE and DONE, count SHALL be ignored; Q SHALL hold 0.
REQ-022 Q SHALL never underflow: 0 SHALL never wrap to all-ones.
REQ-023 Latency from load or clear to Q SHALL be one clock edge.
REQ-024 DONE SHALL be left only via load, clear or reset_n.

Reset
REQ-025 While reset_n=0, the block SHALL immediately and without a clock edge force Q=0, zero=1, expired=0, busy=0, state=IDLE and reload register=0; release SHALL take effect at the first edge after deassertion.

Configuration
REQ-026 Macro COUNTDOWN_TIMER_AUTO_RELOAD_EN SHALL select the terminal-count behaviour:
  - Defined: on terminal count, Q SHALL take the reload register value and state SHALL stay RUN. The period is the reload value in count-enabled cycles, and Q never reaches 0 in RUN.
  - Undefined: on terminal count, Q SHALL become 0 and state SHALL become DONE, with busy falling in the same cycle as the expired pulse.

Verification
REQ-027 Bench SHALL cover, with WIDTH=8:
  - Reset, load=5, then count held 1 (macro undefined) -> Q=5,4,3,2,1,0; expired=1 only in the Q=0 cycle; busy falls in that same cycle; Q then holds 0.
  - DONE or IDLE with count=1 for 10 cycles -> Q stays 8'h00, zero=1, expired stays 0; no wrap to 8'hFF.
  - clear=1 and load=1 with load_value=8'h20 in the same cycle -> Q=0, state IDLE, busy=0.
  - RUN at Q=3, then load with load_value=8'hFF -> Q=8'hFF next edge, decrement continues, no expired pulse.
  - Macro defined, load=3, count continuous -> Q=3,2,1,3,2,1,...; expired pulses every 3rd cycle; busy stays 1.
  - reset_n driven low between clock edges during RUN at Q=8'h40 -> Q=0 and busy=0 before the next clock edge.
